// File: rtl/result_drainer.sv
// result_drainer
//   Reads a contiguous block of words from buffer P and streams them to the
//   host over a valid/ready interface. A 2-entry FIFO absorbs the one-cycle
//   read latency of buffer P and host backpressure, so that with tready_i held
//   high one word per cycle is sustained.
//
// Ports
//   clk_i, rst_ni     clock; asynchronous active-low reset
//   start_i           level start, sampled in IDLE
//   base_addr_i       first P address of the run (latched at start)
//   len_i             number of words of the run (latched at start)
//   done_o            high while in DONE
//   enp_o, addrp_o    buffer P read enable / read address
//   doutp_i           buffer P read data, valid the cycle after enp_o
//   tvalid_o, tready_i, tdata_o, tlast_o
//                     result stream towards the host
module result_drainer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  done_o,
  output logic                  enp_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  input  logic [DATA_WIDTH-1:0] doutp_i,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tlast_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] sent_q, sent_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [2];

  logic                  push;
  logic                  pop;
  logic                  tvalid;
  logic                  tlast;
  logic                  enp;
  logic [2:0]            occ_after_pop;

  // ---------------------------------------------------------------------------
  // Stream-side handshake terms (shared by the FSM and the datapath)
  // ---------------------------------------------------------------------------
  assign tvalid = (fifo_cnt_q != 2'd0);
  assign pop    = tvalid && tready_i;
  assign tlast  = tvalid && (sent_q == (len_q - ADDR_WIDTH'(1)));
  // Read data returns one cycle after the enable, so the registered enable
  // is exactly the FIFO write strobe.
  assign push   = inflight_q;

  // Occupancy once this cycle's pop has left: words already in the FIFO plus
  // the read whose data arrives next edge. A new read is allowed only if its
  // data will still find a free slot.
  assign occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign enp = (state_q == ST_RUN) && (issued_q < len_q) && (occ_after_pop < 3'd2);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (len_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (pop && tlast) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    done_o  = (state_q == ST_DONE);
    enp_o   = enp;
    addrp_o = '0;
    if (enp) begin
      addrp_o = base_q + issued_q;  // wraps modulo 2^ADDR_WIDTH
    end
  end

  assign tvalid_o = tvalid;
  assign tdata_o  = tvalid ? fifo_mem_q[rd_ptr_q] : '0;
  assign tlast_o  = tlast;

  // ---------------------------------------------------------------------------
  // Run bookkeeping and FIFO pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = enp;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (state_q == ST_IDLE && start_i) begin
      base_d   = base_addr_i;
      len_d    = len_i;
      issued_d = '0;
      sent_d   = '0;
    end else begin
      if (enp) begin
        issued_d = issued_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        sent_d = sent_q + ADDR_WIDTH'(1);
      end
    end

    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: one register per entry, written when the write pointer
  // selects it.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
    logic [DATA_WIDTH-1:0] entry_d;

    always_comb begin
      entry_d = fifo_mem_q[gi];
      if (push && (wr_ptr_q == 1'(gi))) begin
        entry_d = doutp_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fifo_mem_q[gi] <= '0;
      end else begin
        fifo_mem_q[gi] <= entry_d;
      end
    end
  end

endmodule

// File: tb/tb_result_drainer.sv
// Testbench for result_drainer: table-driven runs against a behavioural
// buffer P model, plus hand-written sequences for mid-run reset and a start
// level held across DONE.
module tb_result_drainer;

  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] len_i;
  logic          done_o;
  logic          enp_o;
  logic [AW-1:0] addrp_o;
  logic [DW-1:0] doutp_i;
  logic          tvalid_o;
  logic          tready_i;
  logic [DW-1:0] tdata_o;
  logic          tlast_o;

  int n_cmp = 0;
  int n_bad = 0;

  result_drainer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .done_o      (done_o),
    .enp_o       (enp_o),
    .addrp_o     (addrp_o),
    .doutp_i     (doutp_i),
    .tvalid_o    (tvalid_o),
    .tready_i    (tready_i),
    .tdata_o     (tdata_o),
    .tlast_o     (tlast_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer P contents: a fixed function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
  endfunction

  // Buffer P read port: data valid the cycle after the enable.
  always @(posedge clk) begin
    if (enp_o) doutp_i <= mem_word(addrp_o);
  end

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", what, act, exp);
    end
  endtask

  task automatic check_quiet(input string what, input logic exp_done);
    check({what, ".done"},   64'(done_o),   64'(exp_done));
    check({what, ".enp"},    64'(enp_o),    64'(1'b0));
    check({what, ".addrp"},  64'(addrp_o),  64'(16'h0000));
    check({what, ".tvalid"}, 64'(tvalid_o), 64'(1'b0));
    check({what, ".tdata"},  tdata_o,       64'h0);
    check({what, ".tlast"},  64'(tlast_o),  64'(1'b0));
  endtask

  // One run: start in cycle 0, then follow the stream cycle by cycle.
  // Cycle k is the interval from the k-th negedge to the following posedge;
  // inputs change on the negedge and outputs are sampled 1 time unit later.
  task automatic run_case(input string name, input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input logic [7:0] rmask, input int exp_done, input bit hold_start,
                          input int abort_after);
    int issued, sent, first_enp, last_enp, first_tv, done_cyc, occ;
    bit prev_stall, finished;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] exp_addr;
    issued = 0; sent = 0; first_enp = -1; last_enp = -1; first_tv = -1; done_cyc = -1;
    prev_stall = 1'b0; finished = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(negedge clk);
      start_i     = (cyc == 0) || hold_start;
      // After cycle 0 present different values to show they were latched.
      base_addr_i = (cyc == 0) ? base : 16'hBEEF;
      len_i       = (cyc == 0) ? len  : 16'h0003;
      tready_i    = rmask[cyc % 8];
      #1;
      occ = issued - sent;
      check({name, ".occupancy<=2"}, 64'(occ <= 2), 64'(1'b1));
      if (enp_o) begin
        if (first_enp < 0) first_enp = cyc;
        last_enp = cyc;
        exp_addr = base + AW'(issued);
        check({name, ".enp_within_len"}, 64'(issued < int'(len)), 64'(1'b1));
        check({name, ".addrp"}, 64'(addrp_o), 64'(exp_addr));
        issued++;
      end else begin
        check({name, ".addrp_idle"}, 64'(addrp_o), 64'(16'h0000));
      end
      if (prev_stall) begin
        check({name, ".stall_valid"}, 64'(tvalid_o), 64'(1'b1));
        check({name, ".stall_data"}, tdata_o, prev_data);
      end
      if (tvalid_o) begin
        if (first_tv < 0) first_tv = cyc;
        check({name, ".tvalid_within_len"}, 64'(sent < int'(len)), 64'(1'b1));
        check({name, ".tdata"}, tdata_o, mem_word(base + AW'(sent)));
        check({name, ".tlast"}, 64'(tlast_o), 64'(sent == int'(len) - 1));
      end else begin
        check({name, ".tlast_no_valid"}, 64'(tlast_o), 64'(1'b0));
      end
      prev_stall = tvalid_o && !tready_i;
      prev_data  = tdata_o;
      if (tvalid_o && tready_i) begin
        $display("tx %s word %0d data %h last %0b cycle %0d", name, sent, tdata_o, tlast_o, cyc);
        sent++;
        if (sent == abort_after) finished = 1'b1;
      end
      if (done_o) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
    end
    if (abort_after < 0) begin
      check({name, ".done_seen"}, 64'(done_cyc >= 0), 64'(1'b1));
      check({name, ".words_sent"}, 64'(sent), 64'(len));
      check({name, ".reads_issued"}, 64'(issued), 64'(len));
      if (exp_done >= 0) check({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
      if (len != 0) begin
        check({name, ".first_enp_cycle"}, 64'(first_enp), 64'(1));
        check({name, ".first_tvalid_cycle"}, 64'(first_tv), 64'(3));
        if (exp_done >= 0) check({name, ".last_enp_cycle"}, 64'(last_enp), 64'(len));
      end else begin
        check({name, ".no_enp"}, 64'(first_enp), 64'(-1));
        check({name, ".no_tvalid"}, 64'(first_tv), 64'(-1));
      end
    end
  endtask

  // With start_i low in DONE the next cycle is IDLE.
  task automatic back_to_idle(input string name);
    @(negedge clk);
    start_i  = 1'b0;
    tready_i = 1'b1;
    #1;
    check_quiet({name, ".idle"}, 1'b0);
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [7:0]    rmask;
    int            exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"basic4",   16'h0010, 16'd4, 8'hFF,        7};
    vecs[1] = '{"toggle8",  16'h0000, 16'd8, 8'h55,       -1};
    vecs[2] = '{"len0",     16'h1234, 16'd0, 8'hFF,        1};
    vecs[3] = '{"wrap3",    16'hFFFE, 16'd3, 8'hFF,        6};
    vecs[4] = '{"irreg5",   16'h0100, 16'd5, 8'b1100_1001, -1};

    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    tready_i = 1'b0; doutp_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset", 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_quiet("after_reset", 1'b0);

    for (int i = 0; i < 5; i++) begin
      run_case(vecs[i].name, vecs[i].base, vecs[i].len, vecs[i].rmask, vecs[i].exp_done, 1'b0, -1);
      back_to_idle(vecs[i].name);
    end

    // Reset after two handshakes of a 10-word run, then a clean new run.
    run_case("pre_reset", 16'h0300, 16'd10, 8'hFF, -1, 1'b0, 2);
    @(negedge clk);
    rst_ni = 1'b0; start_i = 1'b0;
    #1;
    check_quiet("mid_reset", 1'b0);
    @(negedge clk);
    #1;
    check_quiet("mid_reset_hold", 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_quiet("post_reset", 1'b0);
      @(negedge clk);
    end
    run_case("after_reset_run", 16'h0020, 16'd10, 8'hFF, 13, 1'b0, -1);
    back_to_idle("after_reset_run");

    // start_i held high through DONE: no new run until it drops.
    run_case("hold", 16'h0040, 16'd2, 8'hFF, 5, 1'b1, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_i = 1'b1; base_addr_i = 16'h0777; len_i = 16'd4;
      #1;
      check_quiet("hold_done", 1'b1);
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check_quiet("hold_release", 1'b1);
    run_case("rerun", 16'h0050, 16'd3, 8'hFF, 6, 1'b0, -1);
    back_to_idle("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_drainer.md
Name: result_drainer

Overview:
Reader-side counterpart of the matrix-multiply controller. The controller writes results into global buffer P; this block reads them back out.
- After the host starts it, it reads a contiguous block of words from buffer P's read port.
- It streams those words to the host over a valid/ready interface, with tlast on the final word.
- A 2-entry skid FIFO absorbs the 1-cycle BRAM read latency and host backpressure, so it sustains 1 word/cycle.

Parameters:
ADDR_WIDTH, 16, width of buffer P addresses and of the length count
DATA_WIDTH, 64, width of one buffer P word and of tdata_o

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
start_i  input  1  level start; sampled in IDLE; must be dropped after done_o before the next run
base_addr_i  input  ADDR_WIDTH  first P address to read; latched at start
len_i  input  ADDR_WIDTH  number of words to drain; latched at start
done_o  output  1  high while in DONE
enp_o  output  1  buffer P read enable
addrp_o  output  ADDR_WIDTH  buffer P read address
doutp_i  input  DATA_WIDTH  buffer P read data, valid the cycle after enp_o
tvalid_o  output  1  stream data valid
tready_i  input  1  host ready
tdata_o  output  DATA_WIDTH  stream data
tlast_o  output  1  high with the final word of the run

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters, latched base/len and FIFO contents cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_i=1 and len_i!=0. base_addr_i and len_i are latched in that cycle.
  - IDLE -> DONE when start_i=1 and len_i=0. No read is ever issued.
  - RUN -> DONE in the cycle after the handshake (tvalid_o && tready_i) on the word carrying tlast_o.
  - DONE -> IDLE when start_i=0. Otherwise stay in DONE.
  - start_i is ignored while in RUN.
- Counters: issued (reads issued) and sent (words handshaked), both ADDR_WIDTH wide, cleared on entering RUN.
- Read issue rules:
  - pop = tvalid_o && tready_i.
  - enp_o = (state==RUN) && (issued < len) && (fifo_cnt + inflight - pop < 2). inflight is enp_o registered.
  - addrp_o = base + issued, modulo 2^ADDR_WIDTH (wraps past all-ones to 0). addrp_o is 0 whenever enp_o=0.
- Read data: the cycle after enp_o, doutp_i is pushed into the FIFO. The FIFO never overflows; the occupancy budget counts in-flight reads.
- FIFO and stream output:
  - 2 entries, registered output.
  - tvalid_o = (fifo_cnt != 0). tdata_o = head entry.
  - Push and pop may happen in the same cycle; occupancy is then unchanged.
  - tdata_o and tlast_o hold stable while tvalid_o && !tready_i.
- tlast_o = tvalid_o && (sent == len-1).
- Latency with tready_i held high:
  - Cycle 0: start accepted.
  - Cycle 1: first enp_o.
  - Cycle 3: first tvalid_o.
  - Thereafter one word per cycle with no bubbles.
- Reset mid-run: immediate return to IDLE. Stream data still in the FIFO is discarded, and no tvalid_o follows reset.
- tready_i may be high when tvalid_o=0; this has no effect.

Test Plan:
1. base=0x0010, len=4, tready_i=1 -> enp_o high cycles 1-4 with addrp_o 0x10,0x11,0x12,0x13; tvalid_o cycles 3-6 with tdata_o matching mem[0x10..0x13]; tlast_o only in cycle 6; done_o from cycle 7.
2. base=0, len=8, tready_i toggling 1,0,1,0… -> all 8 words delivered in order, none duplicated or lost; tdata_o stable during stalls; fifo_cnt+inflight never exceeds 2.
3. len=0, start_i=1 -> done_o=1 the next cycle; enp_o and tvalid_o never asserted.
4. base=0xFFFE, len=3 -> addrp_o sequence 0xFFFE, 0xFFFF, 0x0000; tlast_o on the third word.
5. len=10, rst_ni pulsed low after 2 handshakes -> all outputs 0 during reset; a new start with base=0x20 reads from 0x20 and emits exactly len words.
6. start_i held high after done_o -> remains DONE with no reads; start_i low -> IDLE; start_i high again -> new run begins at the newly latched base.
